seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//  Parametrised serial sequence detector, Moore-style registered output. Pattern and length are
//  loaded at run time, up to MAX_LEN bits. Overlapping or non-overlapping mode is selected per load.
//  Sits behind serial front ends (UART/line decoders) to flag framing words and sync marks.
// PARAMETERS
//  MAX_LEN   8   longest detectable pattern, in bits (>=2)
//  LEN_W     4   width of pat_len; must hold MAX_LEN
//  CNT_W     8   width of match_cnt (only with MATCH_CNT_EN)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  cfg_load   in   1        1-cycle pulse: latch pattern/pat_len/ovl_mode
//  pattern    in   MAX_LEN  pattern; bit pat_len-1 is received first, bit 0 last
//  pat_len    in   LEN_W    pattern length in bits
//  ovl_mode   in   1        1 = overlapping, 0 = non-overlapping
//  din_valid  in   1        din is sampled only when high
//  din        in   1        serial data bit
//  dout       out  1        match flag; high for exactly 1 cycle per match
//  armed      out  1        a valid configuration is loaded (state HUNT)
//  match_cnt  out  CNT_W    saturating match count (MATCH_CNT_EN)
//  cnt_clr    in   1        clear match_cnt (MATCH_CNT_EN)
// BEHAVIOUR
//  - Reset: state=UNCFG; history=0, fill=0, dout=0, armed=0, match_cnt=0, cfg regs=0.
//  - FSM has 3 states:
//    UNCFG -cfg_load(valid len)-> HUNT
//    HUNT  -match-> MATCH
//    MATCH -> HUNT, or back to MATCH on a back-to-back match
//    any state -cfg_load(len==0)-> UNCFG
//  - cfg_load: latch pattern, pat_len, ovl_mode. Clear history and fill; match_cnt is kept.
//    pat_len>MAX_LEN is clamped to MAX_LEN.
//    If din_valid is high in the same cycle, the sample is discarded (config wins).
//  - Sampling: on din_valid in HUNT or MATCH:
//    hist <= {hist[MAX_LEN-2:0], din}
//    fill <= min(fill+1, MAX_LEN)
//  - Match condition: (hist_next & mask) == (pattern & mask), with mask = low pat_len bits set,
//    and fill_next >= pat_len.
//  - dout=1 (state MATCH) in the cycle after the completing bit is sampled; 1-cycle latency.
//    dout is 0 in every cycle without a new match, including idle cycles with din_valid=0.
//  - Overlapping mode: history is kept after a match, so the completing bits can start the next match.
//  - Non-overlapping mode: on a match, fill <= 0 (history is masked out), so the next match needs
//    pat_len fresh samples.
//  - Reset mid-stream: partial history is discarded; the first match needs pat_len new samples.
//  - armed=1 in HUNT and MATCH; no match is possible while armed=0.
//  - Width rules: fill saturates at MAX_LEN and never wraps.
// CONFIGURATION
//  MATCH_CNT_EN defined:
//    - match_cnt increments on each dout=1 cycle and saturates at 2^CNT_W-1.
//    - cnt_clr clears it next cycle. If cnt_clr coincides with a match, the result is 0.
//  MATCH_CNT_EN undefined:
//    - counter logic is absent; match_cnt is tied to 0 and cnt_clr is ignored.
// TESTING
//  1. Reset, load 1010/len4/ovl=0, stream 1,0,1,1,1,0,1,0,0,1,1 -> single dout pulse,
//     in the cycle after the 8th bit.
//  2. Same pattern, ovl=1, stream 1,0,1,0,1,0 -> pulses after bit 4 and bit 6.
//     With ovl=0 -> pulse after bit 4 only.
//  3. Load 11/len2/ovl=1, stream 1,1,1,1 with din_valid gaps -> pulses after bits 2, 3 and 4;
//     dout=0 during the gaps.
//  4. Load len0 -> armed=0, no pulses on any stream.
//     Load len12 with MAX_LEN=8 -> behaves as len8.
//  5. Assert rst after 1,0,1 of 1010, then send 0 -> no pulse.
//     cfg_load alongside din_valid -> that bit is ignored.
//  6. MATCH_CNT_EN, CNT_W=2: 5 matches -> match_cnt=3 (saturated).
//     cnt_clr together with a match -> 0.

Source files
------------

// File: rtl/seq_detect_param_if.sv
// Configuration, serial data and match-flag signals of seq_detect_param.
// The master drives configuration and data. The slave (detector) returns the match flag, armed, the counter and its FSM state.
interface seq_detect_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               ovl_mode;
    logic               din_valid;
    logic               din;
    logic               cnt_clr;
    logic               dout;
    logic               armed;
    logic [CNT_W-1:0]   match_cnt;
    logic [1:0]         state_dbg;

    // No handshake back-pressure: din is consumed in every cycle in which din_valid is high.
    // cfg_load is a single-cycle strobe that takes priority over a coincident din_valid.
    modport master (
        output cfg_load, pattern, pat_len, ovl_mode, din_valid, din, cnt_clr,
        input  dout, armed, match_cnt, state_dbg
    );
    modport slave (
        input  cfg_load, pattern, pat_len, ovl_mode, din_valid, din, cnt_clr,
        output dout, armed, match_cnt, state_dbg
    );
endinterface

// File: rtl/seq_detect_param.sv
// Run-time loadable serial pattern detector with a registered (Moore) match flag.
// Optional saturating match counter enabled by defining MATCH_CNT_EN.
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input logic                clk,
    input logic                rst,
    seq_detect_param_if.slave  bus
);
    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        HUNT  = 2'd1,
        MATCH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;

    logic [LEN_W-1:0]   len_clamp;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] hist_nx;
    logic [LEN_W-1:0]   fill_nx;
    logic               sample;
    logic               hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNCFG;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
        end
    end

    always_comb begin
        len_clamp = (bus.pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.pat_len;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        hist_nx = {hist_q[MAX_LEN-2:0], bus.din};
        fill_nx = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        // A load in the same cycle wins over the data bit.
        sample  = bus.din_valid && (state_q != UNCFG) && !bus.cfg_load;
        hit     = sample && (((hist_nx ^ pat_q) & mask) == '0) && (fill_nx >= len_q);
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        if (bus.cfg_load) begin
            pat_d   = bus.pattern;
            len_d   = len_clamp;
            ovl_d   = bus.ovl_mode;
            hist_d  = '0;
            fill_d  = '0;
            state_d = (len_clamp == '0) ? UNCFG : HUNT;
        end else begin
            case (state_q)
                HUNT, MATCH: begin
                    if (sample) begin
                        hist_d  = hist_nx;
                        // Non-overlapping: forget the consumed bits so the next match needs a full fresh pattern.
                        fill_d  = (hit && !ovl_q) ? '0 : fill_nx;
                        state_d = hit ? MATCH : HUNT;
                    end else begin
                        state_d = HUNT;
                    end
                end
                default: state_d = UNCFG;
            endcase
        end
    end

    assign bus.dout      = (state_q == MATCH);
    assign bus.armed     = (state_q != UNCFG);
    assign bus.state_dbg = state_q;

`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            cnt_q <= '0;
        end else if ((state_q == MATCH) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = bus.cnt_clr;
    assign bus.match_cnt  = '0;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed-vector bench for seq_detect_param: the driver queues expected outputs and the monitor checks them.
// Expected match_cnt values follow MATCH_CNT_EN.
module tb_seq_detect_param;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int W       = CNT_W + 3;
`ifdef MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic cur_armed;

    logic [W-1:0] exp_q[$];

    seq_detect_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle of stimulus; the expectation is for the outputs after the next rising edge.
    task automatic cyc(input logic r, input logic cl, input logic v, input logic d,
                       input logic clr, input logic e_dout, input logic e_armed, input int e_cnt);
        logic [W-1:0] ent;
        @(negedge clk);
        rst           = r;
        bus.cfg_load  = cl;
        bus.din_valid = v;
        bus.din       = d;
        bus.cnt_clr   = clr;
        ent = {(e_cnt >= 0), CNT_W'(e_cnt), e_armed, e_dout};
        exp_q.push_back(ent);
    endtask

    task automatic do_rst();
        cur_armed = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ovl, input logic v, input logic d, input logic e_armed);
        bus.pattern  = pat;
        bus.pat_len  = len;
        bus.ovl_mode = ovl;
        cur_armed    = e_armed;
        cyc(1'b0, 1'b1, v, d, 1'b0, 1'b0, e_armed, -1);
    endtask

    // '1'/'0' = valid bit, '-' = idle cycle with random din; e holds the expected dout per step.
    task automatic stream(input string s, input string e);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "-")
                cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, e[i] == "1", cur_armed, -1);
            else
                cyc(1'b0, 1'b0, 1'b1, s[i] == "1", 1'b0, e[i] == "1", cur_armed, -1);
        end
    endtask

    task automatic idle(input logic clr, input logic e_dout, input int e_cnt);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, clr, e_dout, cur_armed, e_cnt);
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        logic [W-1:0] ent;
        #2;
        if (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            n_checks++;
            if (bus.dout !== ent[0]) begin
                n_errors++;
                $display("FAIL dout t=%0t got %b want %b", $time, bus.dout, ent[0]);
            end
            n_checks++;
            if (bus.armed !== ent[1]) begin
                n_errors++;
                $display("FAIL armed t=%0t got %b want %b", $time, bus.armed, ent[1]);
            end
            if (ent[W-1]) begin
                n_checks++;
                if (bus.match_cnt !== ent[CNT_W+1:2]) begin
                    n_errors++;
                    $display("FAIL match_cnt t=%0t got %0d want %0d", $time, bus.match_cnt, ent[CNT_W+1:2]);
                end
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        cur_armed     = 1'b0;
        rst           = 1'b1;
        bus.cfg_load  = 1'b0;
        bus.pattern   = '0;
        bus.pat_len   = '0;
        bus.ovl_mode  = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
        bus.cnt_clr   = 1'b0;

        do_rst();
        do_rst();

        // single non-overlapping match after the 8th bit
        load(8'b1010, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        stream("10111010011", "00000001000");

        // overlapping vs non-overlapping on 101010
        load(8'b1010, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        stream("101010", "000101");
        load(8'b1010, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        stream("101010", "000100");

        // len 2 with valid gaps
        load(8'b11, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        stream("1-1--1-1", "00100101");

        // len 0 disarms; len 12 is clamped to 8
        load(8'b11, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        stream("11111111", "00000000");
        load(8'b10110011, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        stream("10110011", "00000001");
        stream("1110110011", "0000000001");

        // reset mid-pattern discards history
        load(8'b1010, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        stream("101", "000");
        do_rst();
        stream("0", "0");
        load(8'b1010, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        stream("0", "0");
        stream("1010", "0001");

        // bit presented together with cfg_load is dropped
        load(8'b1010, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1);
        stream("01010", "00001");

        // counter saturation and clear-vs-match
        do_rst();
        load(8'b11, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        stream("111111", "011111");
        idle(1'b0, 1'b0, CNT_ON ? 3 : 0);
        idle(1'b1, 1'b0, 0);
        stream("1", "1");
        idle(1'b1, 1'b0, 0);
        stream("1", "1");
        idle(1'b0, 1'b0, CNT_ON ? 1 : 0);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain got %0d want 0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
